bcd_to_bin_seq: RTL and testbench
=================================

# bcd_to_bin_seq

Sequential BCD-to-binary converter, the inverse of the `BCD_16Bit` binary-to-BCD block. It takes five BCD digits (units through ten-thousands) and produces the 16-bit binary value. It uses a start/done handshake and consumes one digit per clock with multiply-by-10 accumulation. It sits between the digit-entry/display datapath and the sequential multiplier's operand registers. It flags values above 65535 and any non-decimal digit.

## Interface
- No parameters; widths are fixed at 5 digits in and 16 bits out.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a conversion; sampled only in IDLE
- uni  input  4  BCD units digit
- dec  input  4  BCD tens digit
- cen  input  4  BCD hundreds digit
- thou  input  4  BCD thousands digit
- thou2  input  4  BCD ten-thousands digit
- bin_out  output  16  converted value, registered, held until the next completion
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle completion pulse
- overflow  output  1  result exceeded 65535; bin_out holds the low 16 bits
- digit_err  output  1  at least one captured digit was greater than 9

## Operation
- **States:** IDLE, CONV. Internal state:
  - 20-bit digit shift register;
  - 17-bit accumulator `acc` (max 99999 < 2^17);
  - 3-bit digit counter.
- **IDLE, start=1, all digits ≤ 9:**
  - Capture {thou2,thou,cen,dec,uni}.
  - Set acc=0, count=0, busy=1.
  - Clear overflow and digit_err.
  - Go to CONV.
- **IDLE, start=1, any digit > 9:**
  - No conversion is performed.
  - Register bin_out=0, overflow=0, digit_err=1, done=1.
  - Stay in IDLE.
- **CONV, each cycle:**
  - acc ← (acc<<3) + (acc<<1) + shreg[19:16], computed at 17-bit width.
  - Shift shreg left by 4, increment count.
- **CONV, count = 4 (fifth digit):**
  - Compute the final acc value as above.
  - Register bin_out=final[15:0], overflow=final[16], done=1, busy=0.
  - Go to IDLE.
- start is ignored while busy=1; no queuing.
- Input digits need to be stable only at the capture edge; they are don't-care afterwards.
- bin_out changes only on a completion edge or on reset. It holds its previous value during CONV.

## Timing
- **Reset (async assert, any state):**
  - All outputs are 0: bin_out=0, busy=0, done=0, overflow=0, digit_err=0.
  - State=IDLE; internal registers cleared.
- Reset mid-conversion aborts the conversion. No done pulse is produced.
- Reset deassertion is used as-is (synchronised upstream).
- **Valid conversion:** start is sampled at edge N.
  - busy is high after edge N.
  - Accumulations occur at edges N+1 … N+5.
  - After edge N+5: done=1 for exactly one cycle, busy=0, results valid.
  - Latency is 5 cycles from the capture edge to done.
- **Invalid digits:** start sampled at edge N → after edge N, done=1 and digit_err=1; latency 1. busy never asserts.
- **Back-to-back:** start high during the done cycle is accepted (state is IDLE). Throughput is one conversion per 6 cycles.
- start held high continuously restarts immediately after each done.
- **Held flags:**
  - overflow and digit_err hold their value until the next accepted start or reset.
  - done never stays high more than one cycle.

## Test plan
- **Basic value:** reset low 2 cycles, then release; digits 1,2,3,4,5 (thou2..uni), start pulse.
  - Expect busy high 5 cycles, then done=1, bin_out=0x3039, overflow=0, digit_err=0.
- **Boundaries:**
  - 6,5,5,3,5 → bin_out=0xFFFF, overflow=0.
  - 6,5,5,3,6 → bin_out=0x0000, overflow=1.
  - 9,9,9,9,9 → bin_out=0x869F, overflow=1.
  - 0,0,0,0,0 → bin_out=0x0000, overflow=0.
- **Invalid digit:** dec=0xA, other digits 0, start.
  - Expect done and digit_err one cycle later, bin_out=0, busy never high.
  - A following valid start clears digit_err.
- **Protocol:**
  - A start pulse during the 3rd CONV cycle with different digits is ignored; the result matches the first operand.
  - start held high gives done pulses every 6 cycles.
- **Reset mid-operation:** assert reset during the 2nd CONV cycle.
  - Expect all outputs 0 immediately (asynchronous) and no done pulse.
  - The next conversion of 0,0,0,4,2 gives 0x002A.
- **Round trip:** random 16-bit values through `BCD_16Bit`, then this block.
  - Expect bin_out equal to the original value, overflow=0, digit_err=0, over ≥1000 values including 0 and 65535.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential five-digit BCD to 16-bit binary converter: one digit per clock,
// multiply-by-10 accumulation, start/done handshake, overflow and bad-digit flags.
module bcd_to_bin_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  uni,
    input  logic [3:0]  dec,
    input  logic [3:0]  cen,
    input  logic [3:0]  thou,
    input  logic [3:0]  thou2,
    output logic [15:0] bin_out,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        digit_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [19:0] r_shreg;
    logic [16:0] r_acc;
    logic [2:0]  r_count;
    logic [15:0] r_bin;
    logic        r_busy;
    logic        r_done;
    logic        r_overflow;
    logic        r_digit_err;

    logic        w_digit_bad;
    logic        w_accept;
    logic        w_reject;
    logic        w_last;
    logic [16:0] w_acc_next;

    function automatic logic is_bad_digit(input logic [3:0] d);
        return d > 4'd9;
    endfunction

    assign w_digit_bad = is_bad_digit(uni)  | is_bad_digit(dec) | is_bad_digit(cen) |
                         is_bad_digit(thou) | is_bad_digit(thou2);
    assign w_accept    = (r_state == S_IDLE) && start && !w_digit_bad;
    assign w_reject    = (r_state == S_IDLE) && start &&  w_digit_bad;
    assign w_last      = (r_state == S_CONV) && (r_count == 3'd4);

    // acc*10 as (acc<<3)+(acc<<1); max 9999*10+9 = 99999 still fits 17 bits.
    assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + {13'd0, r_shreg[19:16]};

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: default assigned first so no path leaves w_state_next unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CONV;
            S_CONV:  if (w_last)   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg     <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_bin       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_digit_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_shreg     <= {thou2, thou, cen, dec, uni};
                r_acc       <= '0;
                r_count     <= '0;
                r_busy      <= 1'b1;
                r_overflow  <= 1'b0;
                r_digit_err <= 1'b0;
            end else if (w_reject) begin
                // Rejected request completes immediately without entering CONV.
                r_bin       <= '0;
                r_overflow  <= 1'b0;
                r_digit_err <= 1'b1;
                r_done      <= 1'b1;
            end else if (r_state == S_CONV) begin
                r_acc   <= w_acc_next;
                r_shreg <= {r_shreg[15:0], 4'd0};
                r_count <= r_count + 3'd1;
                if (w_last) begin
                    r_bin      <= w_acc_next[15:0];
                    r_overflow <= w_acc_next[16];
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
            end
        end
    end

    assign bin_out   = r_bin;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign digit_err = r_digit_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: expected results queued at each request,
// popped and compared when done pulses.
module tb_bcd_to_bin_seq;

    typedef struct {
        logic [15:0] bin;
        logic        ovf;
        logic        derr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  uni, dec, cen, thou, thou2;
    logic [15:0] bin_out;
    logic        busy, done, overflow, digit_err;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    bcd_to_bin_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .uni       (uni),
        .dec       (dec),
        .cen       (cen),
        .thou      (thou),
        .thou2     (thou2),
        .bin_out   (bin_out),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .digit_err (digit_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] t2, t, c, d, u);
        exp_t e;
        int   v;
        v = int'(t2) * 10000 + int'(t) * 1000 + int'(c) * 100 + int'(d) * 10 + int'(u);
        if (t2 > 9 || t > 9 || c > 9 || d > 9 || u > 9) begin
            e.bin = 16'd0; e.ovf = 1'b0; e.derr = 1'b1;
        end else begin
            e.bin = v[15:0]; e.ovf = (v > 65535); e.derr = 1'b0;
        end
        return e;
    endfunction

    // Drives a start pulse across one capture edge, then scrambles the digits.
    task automatic apply(input logic [3:0] t2, t, c, d, u);
        {thou2, thou, cen, dec, uni} = {t2, t, c, d, u};
        start = 1'b1;
        q.push_back(model(t2, t, c, d, u));
        @(posedge clk);
        #1;
        start = 1'b0;
        {thou2, thou, cen, dec, uni} = 20'($urandom);
    endtask

    // Waits for done (bounded), counting negedges and busy cycles, then scores.
    // poke > 0 injects a start with all-9 digits at that negedge.
    task automatic expect_done(input int poke, output int lat, output int busy_cyc);
        exp_t e;
        lat = 0;
        busy_cyc = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (poke > 0 && lat == poke) begin
                start = 1'b1;
                {thou2, thou, cen, dec, uni} = 20'h99999;
            end else if (poke > 0 && lat == poke + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cyc++;
            if (done) break;
            if (lat >= 20) begin
                n_vec++; n_miss++;
                $display("FAIL done_timeout: no done within %0d cycles", lat);
                void'(q.pop_front());
                return;
            end
        end
        n_vec++;
        if (q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty: done seen with no expected entry");
            return;
        end
        e = q.pop_front();
        if (bin_out !== e.bin) begin
            n_miss++;
            $display("FAIL bin_out: got %h expected %h", bin_out, e.bin);
        end
        n_vec++;
        if (overflow !== e.ovf) begin
            n_miss++;
            $display("FAIL overflow: got %b expected %b (bin %h)", overflow, e.ovf, e.bin);
        end
        n_vec++;
        if (digit_err !== e.derr) begin
            n_miss++;
            $display("FAIL digit_err: got %b expected %b (bin %h)", digit_err, e.derr, e.bin);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        {thou2, thou, cen, dec, uni} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bin_out, busy, done, overflow, digit_err} !== 20'd0) begin
            n_miss++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b expected 0000/0000",
                     bin_out, busy, done, overflow, digit_err);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bc;
        @(negedge clk);
        apply(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        expect_done(0, lat, bc);
        n_vec++;
        if (lat !== 6 || bc !== 5) begin
            n_miss++;
            $display("FAIL basic_timing: done at %0d busy %0d expected 6/5", lat, bc);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || bin_out !== 16'h3039) begin
            n_miss++;
            $display("FAIL basic_hold: done %b bin %h expected 0/3039", done, bin_out);
        end
    endtask

    task automatic test_boundaries;
        logic [19:0] vec [4] = '{20'h65535, 20'h65536, 20'h99999, 20'h00000};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply(vec[i][19:16], vec[i][15:12], vec[i][11:8], vec[i][7:4], vec[i][3:0]);
            expect_done(0, lat, bc);
        end
    endtask

    task automatic test_invalid;
        int lat, bc;
        @(negedge clk);
        apply(4'd0, 4'd0, 4'd0, 4'hA, 4'd0);
        expect_done(0, lat, bc);
        n_vec++;
        if (lat !== 1 || bc !== 0) begin
            n_miss++;
            $display("FAIL invalid_timing: done at %0d busy %0d expected 1/0", lat, bc);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || digit_err !== 1'b1) begin
            n_miss++;
            $display("FAIL invalid_hold: done %b digit_err %b expected 0/1", done, digit_err);
        end
        apply(4'd0, 4'd0, 4'd0, 4'd0, 4'd7);
        n_vec++;
        if (digit_err !== 1'b0 || busy !== 1'b1) begin
            n_miss++;
            $display("FAIL invalid_clear: digit_err %b busy %b expected 0/1", digit_err, busy);
        end
        expect_done(0, lat, bc);
    endtask

    task automatic test_ignore_start;
        int lat, bc;
        int extra = 0;
        @(negedge clk);
        apply(4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
        expect_done(3, lat, bc);
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_miss++;
            $display("FAIL ignore_start: got %0d extra done pulses expected 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] vec [3] = '{20'h00042, 20'h12345, 20'h65535};
        int at [3];
        int ndone = 0;
        int cyc = 0;
        @(negedge clk);
        {thou2, thou, cen, dec, uni} = vec[0];
        q.push_back(model(vec[0][19:16], vec[0][15:12], vec[0][11:8], vec[0][7:4], vec[0][3:0]));
        start = 1'b1;
        while (ndone < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                exp_t e = q.pop_front();
                n_vec++;
                if (bin_out !== e.bin || overflow !== e.ovf) begin
                    n_miss++;
                    $display("FAIL b2b_value[%0d]: got %h/%b expected %h/%b",
                             ndone, bin_out, overflow, e.bin, e.ovf);
                end
                at[ndone] = cyc;
                ndone++;
                if (ndone < 3) begin
                    {thou2, thou, cen, dec, uni} = vec[ndone];
                    q.push_back(model(vec[ndone][19:16], vec[ndone][15:12], vec[ndone][11:8],
                                      vec[ndone][7:4], vec[ndone][3:0]));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_vec++;
        if (ndone !== 3 || at[0] !== 6 || at[1] !== 12 || at[2] !== 18) begin
            n_miss++;
            $display("FAIL b2b_spacing: %0d dones at %0d,%0d,%0d expected 3 at 6,12,18",
                     ndone, at[0], at[1], at[2]);
        end
        q.delete();
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        int extra = 0;
        @(negedge clk);
        apply(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({bin_out, busy, done, overflow, digit_err} !== 20'd0) begin
            n_miss++;
            $display("FAIL reset_mid_outputs: got %h/%b%b%b%b expected 0000/0000",
                     bin_out, busy, done, overflow, digit_err);
        end
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_miss++;
            $display("FAIL reset_mid_done: got %0d done pulses expected 0", extra);
        end
        apply(4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
        expect_done(0, lat, bc);
    endtask

    task automatic test_round_trip;
        int lat, bc;
        int v;
        for (int i = 0; i < 1000; i++) begin
            if (i == 0)      v = 0;
            else if (i == 1) v = 65535;
            else             v = int'($urandom_range(0, 65535));
            @(negedge clk);
            apply(4'((v / 10000) % 10), 4'((v / 1000) % 10), 4'((v / 100) % 10),
                  4'((v / 10) % 10), 4'(v % 10));
            expect_done(0, lat, bc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_invalid();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
